// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, reads one word at a time over req/ack,
// and presents the decoded fields until downstream consumes them.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        PCSrc,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    output logic [31:0] Instr,
    output logic [3:0]  Cond,
    output logic [1:0]  Op,
    output logic [5:0]  Funct,
    output logic [3:0]  Rd,
    output logic [31:0] PC,
    output logic [31:0] PCPlus8,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StHold  = 2'd2
    } state_t;

    localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_instr;
    logic [31:0] w_instr_next;
    logic [31:0] r_count;
    logic [31:0] w_count_next;
    logic        r_valid;
    logic        w_valid_next;
    logic        w_unused_tgt_bits;

    // Branch targets are forced word-aligned, so the low bits never matter.
    assign w_unused_tgt_bits = ^branch_target[1:0];

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_instr_next = r_instr;
        w_valid_next = r_valid;
        w_count_next = r_count;
        case (r_state)
            StIdle: begin
                w_state_next = StFetch;
            end
            StFetch: begin
                if (imem_ack) begin
                    w_instr_next = imem_rdata;
                    w_valid_next = 1'b1;
                    w_state_next = StHold;
                end
            end
            StHold: begin
                if (!stall) begin
                    w_pc_next    = PCSrc ? {branch_target[31:2], 2'b00} : r_pc + 32'd4;
                    w_count_next = r_count + 32'd1;
                    w_valid_next = 1'b0;
                    w_state_next = StFetch;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_pc    <= ResetPcAligned;
            r_instr <= 32'd0;
            r_valid <= 1'b0;
            r_count <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_instr <= w_instr_next;
            r_valid <= w_valid_next;
            r_count <= w_count_next;
        end
    end

    assign imem_req    = (r_state == StFetch);
    assign imem_addr   = r_pc;
    assign instr_valid = r_valid;
    assign Instr       = r_instr;
    assign Cond        = r_instr[31:28];
    assign Op          = r_instr[27:26];
    assign Funct       = r_instr[25:20];
    assign Rd          = r_instr[15:12];
    assign PC          = r_pc;
    assign PCPlus8     = r_pc + 32'd8;
    assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table, corner-case sequences and random stimulus
// against a cycle-level reference model; a second instance starts at the top word.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        PCSrc;
    logic [31:0] branch_target;

    logic        a_req, a_valid, b_req, b_valid;
    logic [31:0] a_addr, a_instr, a_pc, a_p8, a_cnt;
    logic [31:0] b_addr, b_instr, b_pc, b_p8, b_cnt;
    logic [3:0]  a_cond, a_rd, b_cond, b_rd;
    logic [1:0]  a_op, b_op;
    logic [5:0]  a_funct, b_funct;

    int total = 0;
    int bad   = 0;

    // Reference model: pipeline occupancy flags plus both PCs.
    bit          m_idle, m_req, m_valid;
    logic [31:0] m_instr, m_pc0, m_pc1, m_cnt;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut_a (
        .clk(clk), .reset(reset), .imem_req(a_req), .imem_addr(a_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .PCSrc(PCSrc),
        .branch_target(branch_target), .instr_valid(a_valid), .Instr(a_instr),
        .Cond(a_cond), .Op(a_op), .Funct(a_funct), .Rd(a_rd), .PC(a_pc),
        .PCPlus8(a_p8), .fetch_count(a_cnt)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .reset(reset), .imem_req(b_req), .imem_addr(b_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .PCSrc(PCSrc),
        .branch_target(branch_target), .instr_valid(b_valid), .Instr(b_instr),
        .Cond(b_cond), .Op(b_op), .Funct(b_funct), .Rd(b_rd), .PC(b_pc),
        .PCPlus8(b_p8), .fetch_count(b_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit ack, input logic [31:0] rd,
                              input bit st, input bit ps, input logic [31:0] tg);
        if (r) begin
            m_idle  = 1'b1;
            m_req   = 1'b0;
            m_valid = 1'b0;
            m_instr = 32'd0;
            m_pc0   = 32'h0000_0000;
            m_pc1   = 32'hFFFF_FFFC;
            m_cnt   = 32'd0;
        end else if (m_idle) begin
            m_idle = 1'b0;
            m_req  = 1'b1;
        end else if (m_req) begin
            if (ack) begin
                m_req   = 1'b0;
                m_valid = 1'b1;
                m_instr = rd;
            end
        end else if (m_valid && !st) begin
            m_valid = 1'b0;
            m_req   = 1'b1;
            m_cnt   = m_cnt + 32'd1;
            if (ps) begin
                m_pc0 = tg & 32'hFFFF_FFFC;
                m_pc1 = tg & 32'hFFFF_FFFC;
            end else begin
                m_pc0 = m_pc0 + 32'd4;
                m_pc1 = m_pc1 + 32'd4;
            end
        end
    endtask

    task automatic compare_model();
        logic [31:0] e_cond, e_op, e_funct, e_rd;
        e_cond  = (m_instr >> 28) & 32'hF;
        e_op    = (m_instr >> 26) & 32'h3;
        e_funct = (m_instr >> 20) & 32'h3F;
        e_rd    = (m_instr >> 12) & 32'hF;
        check("m_req", a_req, m_req);
        check("m_addr", a_addr, m_pc0);
        check("m_valid", a_valid, m_valid);
        check("m_pc", a_pc, m_pc0);
        check("m_pc8", a_p8, m_pc0 + 32'd8);
        check("m_cnt", a_cnt, m_cnt);
        check("m_req_b", b_req, m_req);
        check("m_valid_b", b_valid, m_valid);
        check("m_addr_b", b_addr, m_pc1);
        check("m_pc_b", b_pc, m_pc1);
        check("m_pc8_b", b_p8, m_pc1 + 32'd8);
        check("m_cnt_b", b_cnt, m_cnt);
        if (m_valid) begin
            check("m_instr", a_instr, m_instr);
            check("m_cond", a_cond, e_cond);
            check("m_op", a_op, e_op);
            check("m_funct", a_funct, e_funct);
            check("m_rd", a_rd, e_rd);
            check("m_instr_b", b_instr, m_instr);
            check("m_fields_b", {b_cond, b_op, b_funct, b_rd},
                  {e_cond[3:0], e_op[1:0], e_funct[5:0], e_rd[3:0]});
        end
    endtask

    task automatic apply(input bit r, input bit ack, input logic [31:0] rd,
                         input bit st, input bit ps, input logic [31:0] tg);
        reset         = r;
        imem_ack      = ack;
        imem_rdata    = rd;
        stall         = st;
        PCSrc         = ps;
        branch_target = tg;
        @(posedge clk);
        model_step(r, ack, rd, st, ps, tg);
        #1;
        compare_model();
    endtask

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        stl;
        logic        pcsrc;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_addr_b;
        logic        e_valid;
        logic [3:0]  e_cond;
        logic [3:0]  e_rd;
        logic [5:0]  e_funct;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[11];

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        stall = 1'b0; PCSrc = 1'b0; branch_target = '0;

        tbl[0]  = '{1, 0, 32'h0, 0, 0, 32'h0,         0, 32'h0,   32'hFFFF_FFFC, 0, 4'h0, 4'h0, 6'h00, 0};
        tbl[1]  = '{0, 0, 32'h0, 0, 0, 32'h0,         1, 32'h0,   32'hFFFF_FFFC, 0, 4'h0, 4'h0, 6'h00, 0};
        tbl[2]  = '{0, 1, 32'hE081_2003, 0, 0, 32'h0, 0, 32'h0,   32'hFFFF_FFFC, 1, 4'hE, 4'h2, 6'h08, 0};
        tbl[3]  = '{0, 0, 32'h0, 0, 0, 32'h0,         1, 32'h4,   32'h0,         0, 4'h0, 4'h0, 6'h00, 1};
        tbl[4]  = '{0, 1, 32'h1234_5678, 0, 0, 32'h0, 0, 32'h4,   32'h0,         1, 4'h1, 4'h5, 6'h23, 1};
        tbl[5]  = '{0, 0, 32'h0, 0, 1, 32'h11,        1, 32'h10,  32'h10,        0, 4'h0, 4'h0, 6'h00, 2};
        tbl[6]  = '{0, 1, 32'h3000_7000, 0, 0, 32'h0, 0, 32'h10,  32'h10,        1, 4'h3, 4'h7, 6'h00, 2};
        tbl[7]  = '{0, 1, 32'hFFFF_FFFF, 1, 1, 32'hDEAD, 0, 32'h10, 32'h10,      1, 4'h3, 4'h7, 6'h00, 2};
        tbl[8]  = '{0, 0, 32'h0, 0, 1, 32'h103,       1, 32'h100, 32'h100,       0, 4'h0, 4'h0, 6'h00, 3};
        tbl[9]  = '{0, 1, 32'h9000_B000, 0, 0, 32'h0, 0, 32'h100, 32'h100,       1, 4'h9, 4'hB, 6'h00, 3};
        tbl[10] = '{0, 0, 32'h0, 0, 0, 32'h0,         1, 32'h104, 32'h104,       0, 4'h0, 4'h0, 6'h00, 4};

        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].rst, tbl[i].ack, tbl[i].rdata, tbl[i].stl, tbl[i].pcsrc, tbl[i].tgt);
            check("tbl_req", a_req, tbl[i].e_req);
            check("tbl_addr", a_addr, tbl[i].e_addr);
            check("tbl_addr_b", b_addr, tbl[i].e_addr_b);
            check("tbl_valid", a_valid, tbl[i].e_valid);
            check("tbl_cnt", a_cnt, tbl[i].e_cnt);
            if (tbl[i].e_valid) begin
                check("tbl_cond", a_cond, tbl[i].e_cond);
                check("tbl_rd", a_rd, tbl[i].e_rd);
                check("tbl_funct", a_funct, tbl[i].e_funct);
            end
            if (i == 2) begin
                check("wrap_pc8_b", b_p8, 32'h0000_0004);
                check("basic_pc8", a_p8, 32'h0000_0008);
                check("basic_op", a_op, 2'b00);
            end
        end

        // Slow memory: request held for six FETCH cycles, ack on the last.
        for (int k = 0; k < 5; k++) begin
            apply(0, 0, 32'h0, 0, 0, 32'h0);
            check("slow_req", a_req, 1'b1);
            check("slow_addr", a_addr, 32'h104);
            check("slow_valid", a_valid, 1'b0);
        end
        apply(0, 1, 32'hC000_D000, 0, 0, 32'h0);
        check("slow_valid_rise", a_valid, 1'b1);
        check("slow_rd", a_rd, 4'hD);

        // Stall three cycles, with a bogus branch request that must be ignored.
        for (int k = 0; k < 3; k++) begin
            apply(0, 1, 32'h1111_1111, 1, 1, 32'h40);
            check("stall_valid", a_valid, 1'b1);
            check("stall_instr", a_instr, 32'hC000_D000);
            check("stall_pc", a_pc, 32'h104);
            check("stall_req", a_req, 1'b0);
        end
        apply(0, 0, 32'h0, 0, 1, 32'h8);
        check("stall_consume_addr", a_addr, 32'h8);
        check("stall_consume_cnt", a_cnt, 32'd5);

        // Reset while fetching at 0x8; acks during reset and in IDLE are dropped.
        apply(1, 1, 32'hFFFF_FFFF, 0, 0, 32'h0);
        check("rst_req", a_req, 1'b0);
        check("rst_addr", a_addr, 32'h0);
        check("rst_cnt", a_cnt, 32'd0);
        check("rst_valid", a_valid, 1'b0);
        apply(0, 1, 32'hFFFF_FFFF, 0, 0, 32'h0);
        check("idle_ack_valid", a_valid, 1'b0);
        check("idle_next_req", a_req, 1'b1);
        check("idle_next_addr", a_addr, 32'h0);
        apply(0, 0, 32'h0, 0, 0, 32'h0);
        check("refetch_req", a_req, 1'b1);
        check("refetch_valid", a_valid, 1'b0);

        for (int n = 0; n < 600; n++) begin
            apply($urandom_range(99) < 3, $urandom_range(1), $urandom,
                  $urandom_range(99) < 40, $urandom_range(99) < 30, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage feeding the control unit's input interface; the control unit consumes instruction fields and returns PCSrc.
- Holds the PC and issues one word read at a time to instruction memory over a req/ack handshake.
- Registers the returned word and presents Cond/Op/Funct/Rd with a valid flag until the downstream stage consumes it.
- Applies the branch decision (PCSrc, branch_target) on the consume cycle.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  read request to instruction memory
imem_addr  out  32  word-aligned read address (= PC)
imem_ack  in  1  memory returns data this cycle; sampled only while imem_req=1
imem_rdata  in  32  instruction word, valid when imem_ack=1
stall  in  1  downstream not ready; blocks consumption
PCSrc  in  1  branch taken; sampled only on a consume cycle
branch_target  in  32  branch destination; sampled with PCSrc
instr_valid  out  1  Instr and field outputs hold a fetched instruction
Instr  out  32  registered instruction word
Cond  out  4  Instr[31:28]
Op  out  2  Instr[27:26]
Funct  out  6  Instr[25:20]
Rd  out  4  Instr[15:12]
PC  out  32  address of the instruction in Instr
PCPlus8  out  32  PC + 8, modulo 2^32, combinational from PC
fetch_count  out  32  number of instructions consumed since reset; wraps

Behaviour:
- Reset (synchronous, has priority over all other inputs):
  - state=IDLE, PC=RESET_PC, Instr=0, instr_valid=0, imem_req=0, fetch_count=0.
  - Any in-flight request is abandoned.
- States: IDLE, FETCH, HOLD. imem_req=1 iff state==FETCH (Moore output). imem_addr=PC at all times.
- IDLE → FETCH unconditionally on the next cycle. First request is asserted in the 2nd cycle after reset deasserts. imem_ack in IDLE is ignored.
- FETCH:
  - imem_req and imem_addr are held stable until imem_ack.
  - On imem_ack: Instr<=imem_rdata, instr_valid<=1, state<=HOLD.
  - Latency: ack in cycle N gives valid data in cycle N+1.
  - No timeout; FETCH waits indefinitely.
- HOLD:
  - instr_valid=1; Instr, fields, PC and PCPlus8 are held stable.
  - Consume = (state==HOLD) && !stall.
  - On consume, update PC:
    - PCSrc=1: PC <= {branch_target[31:2],2'b00}.
    - PCSrc=0: PC <= PC+4, modulo 2^32 (0xFFFF_FFFC → 0x0000_0000).
  - Also on consume: fetch_count+=1 (wraps), instr_valid<=0, state<=FETCH. Instr keeps its old value but is don't-care while instr_valid=0.
  - imem_ack in HOLD is ignored.
- Outside a consume cycle, PCSrc and branch_target are ignored.
- Only one outstanding request exists at a time. Peak throughput is 1 instruction per 2 cycles (ack in the same cycle as req, stall=0).
- Reset while in FETCH: the request drops in the cycle after reset is sampled. A late ack is ignored. The PC restarts at RESET_PC.
- Reset while in HOLD: the instruction is discarded without consumption and fetch_count clears.
- Simultaneous reset and ack, or reset and consume: reset wins; no capture, no PC update.

Test Plan:
1. Basic fetch: RESET_PC=0; release reset; imem_ack=1 with rdata=0xE081_2003 in the first FETCH cycle.
   → Next cycle: instr_valid=1, Cond=4'hE, Op=2'b00, Funct=6'b001000, Rd=4'h2, PC=0, PCPlus8=8.
   → With stall=0, the next imem_addr=4 and fetch_count=1.
2. Stall: hold stall=1 for 3 cycles in HOLD.
   → instr_valid, Instr and PC unchanged; imem_req=0 throughout.
   → Consume occurs on the cycle stall drops.
3. Branch: consume at PC=0x10 with PCSrc=1, branch_target=0x0000_0103.
   → Next imem_addr=0x0000_0100.
   → A second instruction consumed there with PCSrc=0 gives the next address 0x104.
4. Wrap: RESET_PC=0xFFFF_FFFC; fetch and consume with PCSrc=0.
   → Next imem_addr=0x0000_0000; PCPlus8 during HOLD at 0xFFFF_FFFC reads 0x0000_0004.
5. Slow memory: delay imem_ack 5 cycles.
   → imem_req=1 and imem_addr constant for all 6 FETCH cycles; instr_valid rises exactly 1 cycle after ack.
6. Reset mid-fetch: assert reset for 1 cycle while in FETCH at PC=0x8; pulse imem_ack during reset and again in IDLE.
   → Both acks ignored; PC=RESET_PC; fetch_count=0; a new request is issued at RESET_PC.
